// File: rtl/iram_fetch_arbiter.sv
// iram_fetch_arbiter
//   Round-robin arbiter in front of the shared single-port instruction RAM.
//   Each cycle it picks one requesting core, drives that core's address to
//   IRAM, and routes the registered RAM word back to that core two cycles later.
//   A per-core saturating stall counter is kept for debug display.
//
// Ports
//   CLK          system clock, shared with IRAM and the cores
//   rst          synchronous active-low reset
//   req          per-core fetch request
//   addr         per-core fetch address, core i at [i*AW +: AW]
//   gnt          one-hot grant, combinational, same cycle as the winning req
//   rdata        per-core returned word, core i at [i*DW +: DW]
//   rvalid       per-core one-cycle strobe marking its rdata slice as fresh
//   ram_address  address to IRAM
//   ram_q        IRAM output, valid the cycle after its address was presented
//   stall_cnt    per-core saturating count of cycles requesting without a grant
module iram_fetch_arbiter #(
    parameter int NCORES = 2,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int SCW    = 8
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic [NCORES-1:0]     req,
    input  logic [NCORES*AW-1:0]  addr,
    output logic [NCORES-1:0]     gnt,
    output logic [NCORES*DW-1:0]  rdata,
    output logic [NCORES-1:0]     rvalid,
    output logic [AW-1:0]         ram_address,
    input  logic [DW-1:0]         ram_q,
    output logic [NCORES*SCW-1:0] stall_cnt
);

    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

    logic [IW-1:0]     last_gnt_q, last_gnt_d;
    logic              tag1_vld_q, tag1_vld_d;
    logic [IW-1:0]     tag1_id_q, tag1_id_d;
    logic [AW-1:0]     addr_hold_q, addr_hold_d;
    logic [NCORES-1:0] rvalid_q;
    logic [DW-1:0]     rdata_q [NCORES];
    logic [SCW-1:0]    stall_q [NCORES];

    logic              win_vld;
    logic [IW-1:0]     win_id;
    logic [IW-1:0]     cand;

    // Search begins one past the last winner and wraps, so the most recently
    // served core has lowest priority. A lone requester still wins every cycle.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int k = 1; k <= NCORES; k++) begin
            cand = IW'((int'(last_gnt_q) + k) % NCORES);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    always_comb begin
        gnt         = '0;
        ram_address = addr_hold_q;
        last_gnt_d  = last_gnt_q;
        tag1_vld_d  = 1'b0;
        tag1_id_d   = tag1_id_q;
        addr_hold_d = addr_hold_q;
        if (rst && win_vld) begin
            gnt[win_id] = 1'b1;
            ram_address = addr[win_id*AW +: AW];
            last_gnt_d  = win_id;
            tag1_vld_d  = 1'b1;
            tag1_id_d   = win_id;
            addr_hold_d = addr[win_id*AW +: AW];
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            // Pointer parked on the last core so core 0 is searched first.
            last_gnt_q  <= IW'(NCORES - 1);
            tag1_vld_q  <= 1'b0;
            tag1_id_q   <= '0;
            addr_hold_q <= '0;
            rvalid_q    <= '0;
            for (int i = 0; i < NCORES; i++) begin
                rdata_q[i] <= '0;
                stall_q[i] <= '0;
            end
        end else begin
            last_gnt_q  <= last_gnt_d;
            tag1_vld_q  <= tag1_vld_d;
            tag1_id_q   <= tag1_id_d;
            addr_hold_q <= addr_hold_d;
            rvalid_q    <= '0;
            if (tag1_vld_q) begin
                rvalid_q[tag1_id_q] <= 1'b1;
                rdata_q[tag1_id_q]  <= ram_q;
            end
            for (int i = 0; i < NCORES; i++) begin
                if (req[i] && !gnt[i] && (stall_q[i] != '1)) begin
                    stall_q[i] <= stall_q[i] + 1'b1;
                end
            end
        end
    end

    assign rvalid = rvalid_q;

    for (genvar g = 0; g < NCORES; g++) begin : g_out
        assign rdata[g*DW +: DW]      = rdata_q[g];
        assign stall_cnt[g*SCW +: SCW] = stall_q[g];
    end

endmodule

// File: tb/tb_iram_fetch_arbiter.sv
module tb_iram_fetch_arbiter;

    logic        CLK = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] addr;
    logic [1:0]  gnt;
    logic [15:0] rdata;
    logic [1:0]  rvalid;
    logic [7:0]  ram_address;
    logic [7:0]  ram_q = 8'h00;
    logic [15:0] stall_cnt;

    int nchk = 0;
    int nerr = 0;

    iram_fetch_arbiter #(.NCORES(2), .AW(8), .DW(8), .SCW(8)) dut (
        .CLK         (CLK),
        .rst         (rst),
        .req         (req),
        .addr        (addr),
        .gnt         (gnt),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .ram_address (ram_address),
        .ram_q       (ram_q),
        .stall_cnt   (stall_cnt)
    );

    always #5 CLK = ~CLK;

    // IRAM model: registered address, contents = address ^ 8'hB5
    always @(posedge CLK) ram_q <= ram_address ^ 8'hB5;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [1:0] eg, ev;
        logic [7:0] ed;

        rst = 1'b0; req = 2'b00; addr = 16'h0000;

        // reset behaviour: no grant while in reset even with requests
        tick(); req = 2'b11; #1;
        chk_val("rst_gnt", gnt, 2'b00);
        tick(); #1;
        chk_val("rst_rvalid", rvalid, 2'b00);
        chk_val("rst_rdata", rdata, 16'h0000);
        chk_val("rst_stall", stall_cnt, 16'h0000);

        // single requester core0, addr 10 -> A5
        tick(); rst = 1'b1; req = 2'b01; addr = 16'h0010; #1;
        chk_val("t1_gnt", gnt, 2'b01);
        chk_val("t1_addr", ram_address, 8'h10);
        tick(); req = 2'b00; #1;
        chk_val("t1_rvalid_lat1", rvalid, 2'b00);
        tick(); #1;
        chk_val("t1_rvalid", rvalid, 2'b01);
        chk_val("t1_rdata0", rdata[7:0], 8'hA5);
        chk_val("t1_stall", stall_cnt, 16'h0000);
        tick(); #1;
        chk_val("t1_rvalid_off", rvalid, 2'b00);

        // simultaneous requests after reset
        tick(); rst = 1'b0;
        tick(); rst = 1'b1; req = 2'b11; addr = {8'h08, 8'h04}; #1;
        chk_val("t2_gnt0", gnt, 2'b01);
        chk_val("t2_addr0", ram_address, 8'h04);
        tick(); req = 2'b10; #1;
        chk_val("t2_gnt1", gnt, 2'b10);
        chk_val("t2_addr1", ram_address, 8'h08);
        tick(); req = 2'b00; #1;
        chk_val("t2_rvalid0", rvalid, 2'b01);
        chk_val("t2_rdata0", rdata[7:0], 8'hB1);
        tick(); #1;
        chk_val("t2_rvalid1", rvalid, 2'b10);
        chk_val("t2_rdata1", rdata[15:8], 8'hBD);
        chk_val("t2_rdata0_hold", rdata[7:0], 8'hB1);
        chk_val("t2_stall", stall_cnt, 16'h0100);
        chk_val("t2_addr_hold", ram_address, 8'h08);

        // continuous requests from both cores for 10 cycles
        tick(); rst = 1'b0;
        tick(); rst = 1'b1; addr = {8'hFF, 8'h20};
        for (int c = 0; c < 12; c++) begin
            req = (c < 10) ? 2'b11 : 2'b00;
            #1;
            eg = (c < 10) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk_val("t3_gnt", gnt, eg);
            if (c >= 2) begin
                ev = ((c - 2) % 2 == 0) ? 2'b01 : 2'b10;
                chk_val("t3_rvalid", rvalid, ev);
                if (ev == 2'b01) chk_val("t3_rdata0", rdata[7:0], 8'h95);
                else             chk_val("t3_rdata1", rdata[15:8], 8'h4A);
            end
            tick();
        end
        chk_val("t3_stall", stall_cnt, 16'h0505);

        // core1 alone: no bubbles; core0 joins and wins at once
        req = 2'b10; addr = {8'h33, 8'h20};
        for (int c = 0; c < 4; c++) begin
            #1;
            chk_val("t4_gnt_solo", gnt, 2'b10);
            tick();
        end
        req = 2'b11; addr = {8'h33, 8'h44}; #1;
        chk_val("t4_gnt_join", gnt, 2'b01);
        tick(); req = 2'b10; #1;
        chk_val("t4_gnt_back", gnt, 2'b10);
        tick(); req = 2'b00; #1;
        chk_val("t4_stall", stall_cnt, 16'h0605);
        chk_val("t4_rvalid0", rvalid, 2'b01);
        chk_val("t4_rdata0", rdata[7:0], 8'hF1);
        tick(); #1;
        chk_val("t4_rvalid1", rvalid, 2'b10);
        chk_val("t4_rdata1", rdata[15:8], 8'h86);

        // reset the cycle after a grant to core1 drops that fetch
        tick(); req = 2'b10; addr = {8'h55, 8'h00}; #1;
        chk_val("t5_gnt", gnt, 2'b10);
        tick(); rst = 1'b0; req = 2'b00; #1;
        chk_val("t5_gnt_rst", gnt, 2'b00);
        tick(); #1;
        chk_val("t5_rvalid", rvalid, 2'b00);
        chk_val("t5_rdata", rdata, 16'h0000);
        chk_val("t5_stall", stall_cnt, 16'h0000);
        tick(); rst = 1'b1; req = 2'b11; addr = {8'h61, 8'h60}; #1;
        chk_val("t5_gnt_first", gnt, 2'b01);
        chk_val("t5_rvalid_none", rvalid, 2'b00);
        tick(); req = 2'b10; #1;
        chk_val("t5_gnt_second", gnt, 2'b10);
        tick(); req = 2'b00; #1;
        chk_val("t5_rvalid0", rvalid, 2'b01);
        chk_val("t5_rdata0", rdata[7:0], 8'hD5);
        tick(); #1;
        ed = 8'hD4;
        chk_val("t5_rvalid1", rvalid, 2'b10);
        chk_val("t5_rdata1", rdata[15:8], ed);

        // stall counter saturation under sustained contention
        tick(); rst = 1'b0;
        tick(); rst = 1'b1; req = 2'b11; addr = {8'h02, 8'h01};
        repeat (200) tick();
        #1;
        chk_val("t6_stall_mid", stall_cnt, 16'h6464);
        repeat (310) tick();
        #1;
        chk_val("t6_stall_sat", stall_cnt, 16'hFFFF);
        repeat (20) tick();
        #1;
        chk_val("t6_stall_nowrap", stall_cnt, 16'hFFFF);
        req = 2'b00;

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
